// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo : FIFO-fed UART transmitter, per-frame 5-8 data bits,
//                none/even/odd parity and 1/2 stop bits.      Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NB_PTR     = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [1:0]         i_data_len,
  input  logic [1:0]         i_parity,
  input  logic               i_two_stop,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow,
  output logic               o_tx_done_tick
);

  localparam int NB_TICK = $clog2(2 * SB_TICK);
  localparam logic [NB_TICK-1:0] c_tick_bit = NB_TICK'(SB_TICK - 1);
  localparam logic [NB_TICK-1:0] c_tick_two = NB_TICK'(2 * SB_TICK - 1);
  localparam logic [NB_PTR:0]    c_depth    = (NB_PTR + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [NB_DATA-1:0] mem_q [FIFO_DEPTH];
  logic [NB_PTR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [NB_PTR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NB_PTR:0]    count_q, count_d;
  logic               ovf_q;

  // Transmitter state
  state_t             state_q;
  logic [NB_TICK-1:0] tick_cnt_q;
  logic [2:0]         bit_cnt_q;
  logic [NB_DATA-1:0] shift_q;
  logic               par_acc_q;
  logic [1:0]         len_q;
  logic [1:0]         par_mode_q;
  logic               two_stop_q;
  logic               tx_q;
  logic               done_q;

  logic               fifo_empty;
  logic               fifo_full;
  logic               bit_end;
  logic               stop_end;
  logic               pop;
  logic               push;
  logic [2:0]         last_bit;
  logic               par_en;
  logic               par_odd;
  logic [NB_DATA-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == c_depth);
  assign head       = mem_q[rd_ptr_q];

  assign bit_end  = i_tick && (tick_cnt_q == c_tick_bit);
  assign stop_end = i_tick && (tick_cnt_q == (two_stop_q ? c_tick_two : c_tick_bit));

  // The FSM pops from IDLE, or from the last stop tick to chain frames.
  assign pop  = !fifo_empty &&
                ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_end));
  assign push = i_wr && (!fifo_full || pop);

  assign last_bit = {1'b0, len_q} + 3'd4;
  assign par_en   = ^par_mode_q;
  assign par_odd  = (par_mode_q == 2'b10);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= i_wr && !push;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      len_q      <= 2'b00;
      par_mode_q <= 2'b00;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_tick) begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          tx_q       <= 1'b1;
          tick_cnt_q <= '0;
          if (pop) begin
            state_q    <= ST_START;
            tx_q       <= 1'b0;
            shift_q    <= head;
            par_acc_q  <= 1'b0;
            len_q      <= i_data_len;
            par_mode_q <= i_parity;
            two_stop_q <= i_two_stop;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q    <= ST_DATA;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            tick_cnt_q <= '0;
            shift_q    <= shift_q >> 1;
            par_acc_q  <= par_acc_q ^ shift_q[0];
            if (bit_cnt_q == last_bit) begin
              if (par_en) begin
                state_q <= ST_PARITY;
                tx_q    <= par_acc_q ^ shift_q[0] ^ par_odd;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q    <= ST_STOP;
            tick_cnt_q <= '0;
            tx_q       <= 1'b1;
          end
        end
        ST_STOP: begin
          if (stop_end) begin
            done_q     <= 1'b1;
            tick_cnt_q <= '0;
            if (pop) begin
              state_q    <= ST_START;
              tx_q       <= 1'b0;
              shift_q    <= head;
              par_acc_q  <= 1'b0;
              len_q      <= i_data_len;
              par_mode_q <= i_parity;
              two_stop_q <= i_two_stop;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tick_cnt_q <= '0;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx           = tx_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_empty        = fifo_empty;
  assign o_full         = fifo_full;
  assign o_overflow     = ovf_q;
  assign o_tx_done_tick = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CAP = 1100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] len = 2'b11;
  logic [1:0] par = 2'b00;
  logic       two_stop = 1'b0;
  logic       o_tx, o_busy, o_empty, o_full, o_overflow, o_tx_done_tick;

  int n_cmp = 0;
  int n_fail = 0;
  int tick_period = 1;
  int tick_cnt = 0;

  logic tx_s    [CAP];
  logic done_s  [CAP];
  logic busy_s  [CAP];
  logic ovf_s   [CAP];
  logic empty_s [CAP];

  uart_tx_fifo #(
    .NB_DATA(8), .SB_TICK(16), .FIFO_DEPTH(4), .NB_PTR(2)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_wr(wr), .i_data(data),
    .i_data_len(len), .i_parity(par), .i_two_stop(two_stop),
    .o_tx(o_tx), .o_busy(o_busy), .o_empty(o_empty), .o_full(o_full),
    .o_overflow(o_overflow), .o_tx_done_tick(o_tx_done_tick)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt + 1) % tick_period;
      tick = (tick_cnt == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic capture(input int start, input int n);
    for (int j = start; j < start + n; j++) begin
      @(negedge clk);
      tx_s[j]    = o_tx;
      done_s[j]  = o_tx_done_tick;
      busy_s[j]  = o_busy;
      ovf_s[j]   = o_overflow;
      empty_s[j] = o_empty;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] l, input logic [1:0] p, input logic t);
    wr = 1'b1; data = d; len = l; par = p; two_stop = t;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", o_tx); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", o_empty); end
    n_cmp++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
    n_cmp++; if (o_tx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_tx_done_tick); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    logic [9:0] exp;
    int ndone;
    exp = {1'b1, 8'hA5, 1'b0};
    push(8'hA5, 2'b11, 2'b00, 1'b0);
    n_cmp++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL 8n1_empty_after_wr: got %b want 0", o_empty); end
    n_cmp++; if (o_tx !== 1'b1) begin n_fail++; $display("FAIL 8n1_idle_before_start: got %b want 1", o_tx); end
    capture(0, 200);
    n_cmp++; if (tx_s[0] !== 1'b0) begin n_fail++; $display("FAIL 8n1_start_latency: got %b want 0", tx_s[0]); end
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (tx_s[16*b+8] !== exp[b]) begin
        n_fail++; $display("FAIL 8n1_bit%0d: got %b want %b", b, tx_s[16*b+8], exp[b]);
      end
    end
    ndone = 0;
    for (int j = 0; j < 200; j++) if (done_s[j] === 1'b1) ndone++;
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL 8n1_done_count: got %0d want 1", ndone); end
    n_cmp++; if (done_s[160] !== 1'b1) begin n_fail++; $display("FAIL 8n1_done_at_160: got %b want 1", done_s[160]); end
    n_cmp++; if (busy_s[159] !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy_in_stop: got %b want 1", busy_s[159]); end
    n_cmp++; if (busy_s[160] !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_after: got %b want 0", busy_s[160]); end
  endtask

  task automatic test_parity_stop();
    logic [9:0]  exp_e;
    logic [10:0] exp_o;
    int ones;
    exp_e = {1'b1, 1'b0, 7'h35, 1'b0};
    exp_o = {2'b11, 1'b1, 7'h35, 1'b0};
    push(8'h35, 2'b10, 2'b01, 1'b0);
    capture(0, 200);
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (tx_s[16*b+8] !== exp_e[b]) begin
        n_fail++; $display("FAIL 7e1_bit%0d: got %b want %b", b, tx_s[16*b+8], exp_e[b]);
      end
    end
    n_cmp++; if (done_s[160] !== 1'b1) begin n_fail++; $display("FAIL 7e1_done_at_160: got %b want 1", done_s[160]); end
    push(8'h35, 2'b10, 2'b10, 1'b1);
    capture(0, 200);
    for (int b = 0; b < 11; b++) begin
      n_cmp++;
      if (tx_s[16*b+8] !== exp_o[b]) begin
        n_fail++; $display("FAIL 7o2_bit%0d: got %b want %b", b, tx_s[16*b+8], exp_o[b]);
      end
    end
    ones = 0;
    for (int j = 144; j < 176; j++) if (tx_s[j] === 1'b1) ones++;
    n_cmp++; if (ones != 32) begin n_fail++; $display("FAIL 7o2_stop_len: got %0d want 32", ones); end
    n_cmp++; if (done_s[160] !== 1'b0) begin n_fail++; $display("FAIL 7o2_no_early_done: got %b want 0", done_s[160]); end
    n_cmp++; if (done_s[176] !== 1'b1) begin n_fail++; $display("FAIL 7o2_done_at_176: got %b want 1", done_s[176]); end
  endtask

  task automatic test_5bit();
    logic [6:0] exp;
    int ndone;
    exp = {1'b1, 5'h1F, 1'b0};
    push(8'hFF, 2'b00, 2'b00, 1'b0);
    capture(0, 150);
    for (int b = 0; b < 7; b++) begin
      n_cmp++;
      if (tx_s[16*b+8] !== exp[b]) begin
        n_fail++; $display("FAIL 5n1_bit%0d: got %b want %b", b, tx_s[16*b+8], exp[b]);
      end
    end
    ndone = 0;
    for (int j = 0; j < 150; j++) if (done_s[j] === 1'b1) ndone++;
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL 5n1_done_count: got %0d want 1", ndone); end
    n_cmp++; if (done_s[111] !== 1'b0) begin n_fail++; $display("FAIL 5n1_no_early_done: got %b want 0", done_s[111]); end
    n_cmp++; if (done_s[112] !== 1'b1) begin n_fail++; $display("FAIL 5n1_done_at_112: got %b want 1", done_s[112]); end
  endtask

  task automatic test_back_to_back();
    logic       full_k [6];
    logic       ovf_k  [6];
    logic [7:0] d;
    logic [9:0] exp;
    int idx;
    int ndone;
    wr = 1'b1; len = 2'b11; par = 2'b00; two_stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      data = 8'(k + 1);
      @(negedge clk);
      full_k[k] = o_full;
      ovf_k[k]  = o_overflow;
    end
    wr = 1'b0;
    n_cmp++; if (full_k[3] !== 1'b0) begin n_fail++; $display("FAIL b2b_full_after4: got %b want 0", full_k[3]); end
    n_cmp++; if (full_k[4] !== 1'b1) begin n_fail++; $display("FAIL b2b_full_after5: got %b want 1", full_k[4]); end
    n_cmp++; if (ovf_k[4] !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_early: got %b want 0", ovf_k[4]); end
    n_cmp++; if (ovf_k[5] !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf_pulse: got %b want 1", ovf_k[5]); end
    capture(0, 820);
    n_cmp++; if (ovf_s[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_one_cycle: got %b want 0", ovf_s[0]); end
    for (int f = 0; f < 5; f++) begin
      d = 8'(f + 1);
      exp = {1'b1, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
        idx = 160*f + 16*b + 3;
        n_cmp++;
        if (tx_s[idx] !== exp[b]) begin
          n_fail++; $display("FAIL b2b_f%0d_bit%0d: got %b want %b", f, b, tx_s[idx], exp[b]);
        end
      end
      idx = 160*(f + 1) - 5;
      n_cmp++;
      if (done_s[idx] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_f%0d_done: got %b want 1", f, done_s[idx]);
      end
      if (f < 4) begin
        n_cmp++;
        if (tx_s[idx] !== 1'b0) begin
          n_fail++; $display("FAIL b2b_f%0d_no_gap: got %b want 0", f, tx_s[idx]);
        end
      end
    end
    ndone = 0;
    for (int j = 0; j < 820; j++) if (done_s[j] === 1'b1) ndone++;
    n_cmp++; if (ndone != 5) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 5", ndone); end
    n_cmp++; if (busy_s[819] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy_s[819]); end
    n_cmp++; if (empty_s[819] !== 1'b1) begin n_fail++; $display("FAIL b2b_empty_end: got %b want 1", empty_s[819]); end
  endtask

  task automatic test_reset_mid();
    int ones;
    int ndone;
    wr = 1'b1; data = 8'h00; len = 2'b11; par = 2'b00; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    wr = 1'b0;
    repeat (70) @(negedge clk);
    n_cmp++; if (o_tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_data: got %b want 0", o_tx); end
    n_cmp++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL rstmid_queued: got %b want 0", o_empty); end
    rst = 1'b1;
    #1;
    n_cmp++; if (o_tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_async: got %b want 1", o_tx); end
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b want 1", o_empty); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    capture(0, 400);
    ones = 0; ndone = 0;
    for (int j = 0; j < 400; j++) begin
      if (tx_s[j] === 1'b1) ones++;
      if (done_s[j] === 1'b1) ndone++;
    end
    n_cmp++; if (ones != 400) begin n_fail++; $display("FAIL rstmid_line_idle: got %0d want 400", ones); end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", ndone); end
    n_cmp++; if (empty_s[399] !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty_end: got %b want 1", empty_s[399]); end
  endtask

  task automatic test_slow_tick();
    int tr [16];
    int ntr;
    int done_idx;
    int ndone;
    tick_period = 4;
    for (int k = 0; k < 16; k++) tr[k] = -10000;
    push(8'h55, 2'b11, 2'b00, 1'b0);
    capture(0, 100);
    len = 2'b00; par = 2'b01; two_stop = 1'b1;
    capture(100, 650);
    ntr = 0; done_idx = -10000; ndone = 0;
    for (int j = 1; j < 750; j++) begin
      if (tx_s[j] !== tx_s[j-1]) begin
        if (ntr < 16) tr[ntr] = j;
        ntr++;
      end
    end
    for (int j = 0; j < 750; j++) begin
      if (done_s[j] === 1'b1) begin
        if (ndone == 0) done_idx = j;
        ndone++;
      end
    end
    n_cmp++; if (tx_s[0] !== 1'b0) begin n_fail++; $display("FAIL slow_start: got %b want 0", tx_s[0]); end
    n_cmp++; if (ntr != 9) begin n_fail++; $display("FAIL slow_edges: got %0d want 9", ntr); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (tr[k+1] - tr[k] != 64) begin
        n_fail++; $display("FAIL slow_bit%0d_len: got %0d want 64", k + 1, tr[k+1] - tr[k]);
      end
    end
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL slow_done_count: got %0d want 1", ndone); end
    n_cmp++; if (done_idx - tr[8] != 64) begin n_fail++; $display("FAIL slow_stop_len: got %0d want 64", done_idx - tr[8]); end
    tick_period = 1;
    len = 2'b11; par = 2'b00; two_stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_stop();
    test_5bit();
    test_back_to_back();
    test_reset_mid();
    test_slow_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and per-frame run-time framing (5–8 data bits, none/even/odd parity, 1 or 2 stop bits). It sits between the host-side byte producer and the serial TX pin. It consumes the oversampling tick from the baud generator. It sends queued frames back-to-back with no idle gap.

## Interface

- `NB_DATA`, 8: maximum data width; the width of `i_data`.
- `SB_TICK`, 16: baud ticks per bit (oversampling factor).
- `FIFO_DEPTH`, 4: number of FIFO entries; must be a power of two, ≥ 2.
- `NB_PTR`, 2: log2(`FIFO_DEPTH`).

- `i_clk`, in, 1: system clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_tick`, in, 1: one-cycle baud-tick strobe from the baud generator.
- `i_wr`, in, 1: push `i_data` into the FIFO.
- `i_data`, in, `NB_DATA`: byte to transmit; LSB is sent first.
- `i_data_len`, in, 2: data bits per frame; 00=5, 01=6, 10=7, 11=8.
- `i_parity`, in, 2: parity mode; 00=none, 01=even, 10=odd, 11=none.
- `i_two_stop`, in, 1: 1 selects two stop bits.
- `o_tx`, out, 1: serial line. Registered; idle level is 1.
- `o_busy`, out, 1: FSM is not in IDLE.
- `o_empty`, out, 1: FIFO is empty.
- `o_full`, out, 1: FIFO is full.
- `o_overflow`, out, 1: one-cycle pulse when a write is dropped.
- `o_tx_done_tick`, out, 1: one-cycle pulse at the end of each frame.

## Operation

- **Reset values:** `o_tx`=1, `o_busy`=0, `o_empty`=1, `o_full`=0, `o_overflow`=0, `o_tx_done_tick`=0. Reset clears the FIFO pointers and count, the FSM, and all counters.
- **FIFO:** circular buffer with write/read pointers and a count of width `NB_PTR`+1.
  - A write is accepted when `!o_full`, or when a pop occurs in the same cycle.
  - Otherwise the write is dropped and `o_overflow` pulses.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `o_tx`=1. If `!o_empty`, the FSM pops the head entry into the shift register and moves to START. On this pop it latches `i_data_len`, `i_parity` and `i_two_stop` into frame-config registers. Config changes mid-frame have no effect on the current frame.
- **Tick counter:** counts `i_tick` and is cleared on every state change. A bit ends on the tick where the counter equals `SB_TICK-1`.
- **START:** `o_tx`=0 for one bit. Then go to DATA with bit counter = 0.
- **DATA:** `o_tx`=shift[0]. At the end of each bit, shift right and increment the bit counter. After bit index n−1 (n = 5..8), go to PARITY if parity is enabled, else to STOP. Bits at positions n and above of the byte are never sent.
- **Parity calculation:** the parity value is the XOR of the n sent data bits for even parity, and its inverse for odd parity. It is accumulated while shifting.
- **PARITY:** `o_tx`=parity for one bit, then go to STOP.
- **STOP:** `o_tx`=1 for `SB_TICK` ticks, or 2·`SB_TICK` ticks when two stop bits are latched (the counter is widened to cover 2·`SB_TICK`−1). At the end of STOP, `o_tx_done_tick` pulses.
  - If the FIFO is non-empty, the FSM pops in the same cycle and enters START directly.
  - Otherwise it goes to IDLE.
- **Illegal state:** recovers to IDLE with `o_tx`=1.

## Timing

- `o_tx` is registered and updates on the same edge as the state register. Each bit lasts exactly `SB_TICK` `i_tick` strobes.
- **Latency:** `i_wr` is sampled at edge E0 into an empty FIFO with the FSM in IDLE. `o_empty` falls after E0. The pop and START entry happen at E1, so `o_tx`=0 from E1.
- **Back-to-back frames:** the STOP→START transition produces no extra idle-high cycles. Frame period = (1 + n + p + s)·`SB_TICK` ticks.
- `o_full` and `o_empty` reflect the count after the current edge. A pop and a push in the same cycle leave the count unchanged.
- **Reset mid-frame:** `o_tx` goes to 1 asynchronously. Queued data is discarded. No `o_tx_done_tick` is generated.
- `i_tick` absent: the FSM holds its state and `o_tx` indefinitely.

## Test plan

1. **8N1, one byte.** Setup: `i_tick` every clock, push 0xA5 with 8N1. Required `o_tx` sequence, 16 clocks per bit: 0,1,0,1,0,0,1,0,1,1. One `o_tx_done_tick` pulse, 160 clocks after START entry. Then `o_busy`=0.
2. **Parity and two stop bits.** Push 0x35 as 7E1: the parity bit is 0. Push 0x35 as 7O2: the parity bit is 1 and the stop level lasts 32 ticks.
3. **5-bit frame.** Push 0xFF as 5N1. Required: exactly 5 one-bits, then the stop bit. Frame length 112 ticks.
4. **Overflow and back-to-back.** `FIFO_DEPTH`=4. Push bytes 0x01..0x06 on six consecutive cycles. Required: 0x01 is popped at E1 and 0x02..0x05 are queued. `o_full`=1 after the fifth push. 0x06 is dropped with one `o_overflow` pulse. Five frames (0x01..0x05) go out contiguously, with five done pulses and no idle gap.
5. **Reset mid-DATA.** Assert `i_reset` during bit 3 of a frame with 2 entries queued. Required: `o_tx`=1 immediately, `o_empty`=1, no done pulse, and no transmission after release.
6. **Slow tick.** `i_tick` once every 4 clocks. Required: each bit lasts 64 clocks, and config changed mid-frame does not alter the frame in flight.
